// File: rtl/adder_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_arbiter_pkg                                                        |
// | Shared FSM encoding and float helpers for the adder_arbiter slice.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package adder_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int SIGN_BIT = 31;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_SEND_A = 3'd2,
    ST_SEND_B = 3'd3,
    ST_WAIT_Z = 3'd4,
    ST_RETURN = 3'd5
  } state_e;

  // Subtraction is realised purely as a sign-bit flip, so NaN payloads pass through.
  function automatic logic [DATA_W-1:0] flip_sign(input logic [DATA_W-1:0] v);
    return {~v[SIGN_BIT], v[SIGN_BIT-1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick                                                                  |
// | Combinational round-robin picker; search starts at last_i+1 mod N.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_pick
  import adder_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    winner_o = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IDX_W'((int'(last_i) + k) % N);
      if (req_i[cand]) begin
        winner_o = cand;
        any_o    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_arbiter                                                            |
// | Round-robin sharing of one float adder among N requesters.               |
// | Optional feature: ADDER_ARBITER_SUB_EN adds req_sub (compute a-b).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [32*N-1:0]     req_a,
  input  logic [32*N-1:0]     req_b,
`ifdef ADDER_ARBITER_SUB_EN
  input  logic [N-1:0]        req_sub,
`endif
  input  logic [N-1:0]        req_stb,
  output logic [N-1:0]        req_ack,
  output logic [31:0]         res_z,
  output logic [N-1:0]        res_stb,
  input  logic [N-1:0]        res_ack,
  output logic [31:0]         adder_a,
  output logic                adder_a_stb,
  input  logic                adder_a_ack,
  output logic [31:0]         adder_b,
  output logic                adder_b_stb,
  input  logic                adder_b_ack,
  input  logic [31:0]         adder_z,
  input  logic                adder_z_stb,
  output logic                adder_z_ack,
  output logic                busy,
  output logic [IDX_W-1:0]    grant
);

  state_e            state_q;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  last_q;
  logic [N-1:0]      req_ack_q;
  logic [N-1:0]      res_stb_q;
  logic [31:0]       res_z_q;
  logic [31:0]       adder_a_q;
  logic              adder_a_stb_q;
  logic [31:0]       adder_b_q;
  logic              adder_b_stb_q;
  logic              adder_z_ack_q;
  logic              busy_q;
  logic [31:0]       op_b_q;
  logic [31:0]       adder_b_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  logic [31:0]       a_arr [N];
  logic [31:0]       b_arr [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end

`ifdef ADDER_ARBITER_SUB_EN
  logic sub_q;
  assign adder_b_d = sub_q ? flip_sign(op_b_q) : op_b_q;
`else
  assign adder_b_d = op_b_q;
`endif

  rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i    (req_stb),
    .last_i   (last_q),
    .winner_o (pick_idx),
    .any_o    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_q        <= IDX_W'(N - 1);
      req_ack_q     <= '0;
      res_stb_q     <= '0;
      res_z_q       <= '0;
      adder_a_q     <= '0;
      adder_a_stb_q <= 1'b0;
      adder_b_q     <= '0;
      adder_b_stb_q <= 1'b0;
      adder_z_ack_q <= 1'b0;
      busy_q        <= 1'b0;
      op_b_q        <= '0;
`ifdef ADDER_ARBITER_SUB_EN
      sub_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q   <= pick_idx;
            req_ack_q <= N'(1) << pick_idx;
            busy_q    <= 1'b1;
            state_q   <= ST_ACCEPT;
          end
        end
        ST_ACCEPT: begin
          if (req_stb[grant_q] && req_ack_q[grant_q]) begin
            req_ack_q     <= '0;
            adder_a_q     <= a_arr[grant_q];
            op_b_q        <= b_arr[grant_q];
`ifdef ADDER_ARBITER_SUB_EN
            sub_q         <= req_sub[grant_q];
`endif
            adder_a_stb_q <= 1'b1;
            state_q       <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          if (adder_a_stb_q && adder_a_ack) begin
            adder_a_stb_q <= 1'b0;
            adder_b_q     <= adder_b_d;
            adder_b_stb_q <= 1'b1;
            state_q       <= ST_SEND_B;
          end
        end
        ST_SEND_B: begin
          if (adder_b_stb_q && adder_b_ack) begin
            adder_b_stb_q <= 1'b0;
            adder_z_ack_q <= 1'b1;
            state_q       <= ST_WAIT_Z;
          end
        end
        ST_WAIT_Z: begin
          if (adder_z_stb && adder_z_ack_q) begin
            adder_z_ack_q <= 1'b0;
            res_z_q       <= adder_z;
            res_stb_q     <= N'(1) << grant_q;
            state_q       <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          // Finishing owner becomes lowest priority for the next arbitration.
          if (res_stb_q[grant_q] && res_ack[grant_q]) begin
            res_stb_q <= '0;
            last_q    <= grant_q;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack     = req_ack_q;
  assign res_stb     = res_stb_q;
  assign res_z       = res_z_q;
  assign adder_a     = adder_a_q;
  assign adder_a_stb = adder_a_stb_q;
  assign adder_b     = adder_b_q;
  assign adder_b_stb = adder_b_stb_q;
  assign adder_z_ack = adder_z_ack_q;
  assign busy        = busy_q;
  assign grant       = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_adder_arbiter                                                         |
// | Directed bench with a handshake adder model built from known sums.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_adder_arbiter;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [32*N-1:0]  req_a, req_b;
`ifdef ADDER_ARBITER_SUB_EN
  logic [N-1:0]     req_sub;
`endif
  logic [N-1:0]     req_stb, req_ack, res_stb, res_ack;
  logic [31:0]      res_z, adder_a, adder_b, adder_z;
  logic             adder_a_stb, adder_a_ack, adder_b_stb, adder_b_ack;
  logic             adder_z_stb, adder_z_ack, busy;
  logic [IDX_W-1:0] grant;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  adder_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_a       (req_a),
    .req_b       (req_b),
`ifdef ADDER_ARBITER_SUB_EN
    .req_sub     (req_sub),
`endif
    .req_stb     (req_stb),
    .req_ack     (req_ack),
    .res_z       (res_z),
    .res_stb     (res_stb),
    .res_ack     (res_ack),
    .adder_a     (adder_a),
    .adder_a_stb (adder_a_stb),
    .adder_a_ack (adder_a_ack),
    .adder_b     (adder_b),
    .adder_b_stb (adder_b_stb),
    .adder_b_ack (adder_b_ack),
    .adder_z     (adder_z),
    .adder_z_stb (adder_z_stb),
    .adder_z_ack (adder_z_ack),
    .busy        (busy),
    .grant       (grant)
  );

  // Adder stand-in: only the hand-computed operand pairs used here are known.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000; // 1+1
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000; // 2+2
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000; // 1+2
      {32'h4000_0000, 32'h4080_0000}: return 32'h40C0_0000; // 2+4
      {32'h4040_0000, 32'h3F80_0000}: return 32'h4080_0000; // 3+1
      {32'h4040_0000, 32'hBF80_0000}: return 32'h4000_0000; // 3+(-1)
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  int          ad_st;
  int          lat_cnt;
  logic [31:0] lat_a, lat_b;

  always @(posedge clk) begin
    if (rst) begin
      ad_st       <= 0;
      lat_cnt     <= 0;
      lat_a       <= '0;
      lat_b       <= '0;
      adder_a_ack <= 1'b0;
      adder_b_ack <= 1'b0;
      adder_z_stb <= 1'b0;
      adder_z     <= '0;
    end else begin
      case (ad_st)
        0: begin
          adder_a_ack <= 1'b1;
          if (adder_a_stb && adder_a_ack) begin
            lat_a <= adder_a; adder_a_ack <= 1'b0; ad_st <= 1;
          end
        end
        1: begin
          adder_b_ack <= 1'b1;
          if (adder_b_stb && adder_b_ack) begin
            lat_b <= adder_b; adder_b_ack <= 1'b0; lat_cnt <= 3; ad_st <= 2;
          end
        end
        2: begin
          if (lat_cnt == 0) begin
            adder_z <= ref_add(lat_a, lat_b); adder_z_stb <= 1'b1; ad_st <= 3;
          end else begin
            lat_cnt <= lat_cnt - 1;
          end
        end
        default: begin
          if (adder_z_stb && adder_z_ack) begin
            adder_z_stb <= 1'b0; ad_st <= 0;
          end
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic set_ops(input int idx, input logic [31:0] a, input logic [31:0] b, input logic sub);
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
`ifdef ADDER_ARBITER_SUB_EN
    req_sub[idx] = sub;
`else
    if (sub) $display("note: sub requested in add-only build");
`endif
  endtask

  task automatic wait_accept(input int idx);
    int cyc = 0;
    do begin @(negedge clk); cyc++; end while (req_ack == '0 && cyc < 40);
    if (req_ack == '0) timeout("req_ack");
    else begin
      check("req_ack onehot", 32'(req_ack), 32'(1) << idx);
      check("grant", 32'(grant), 32'(idx));
      check("busy in accept", 32'(busy), 32'd1);
    end
    @(negedge clk);
    req_stb[idx] = 1'b0;
    check("req_ack dropped", 32'(req_ack), 32'd0);
  endtask

  task automatic wait_result(input int idx, input logic [31:0] z);
    int cyc = 0;
    while (res_stb == '0 && cyc < 60) begin @(negedge clk); cyc++; end
    if (res_stb == '0) timeout("res_stb");
    else begin
      check("res_stb owner", 32'(res_stb), 32'(1) << idx);
      check("res_z", res_z, z);
      check("grant in return", 32'(grant), 32'(idx));
    end
  endtask

  task automatic take_result(input int idx);
    res_ack[idx] = 1'b1;
    @(negedge clk);
    res_ack[idx] = 1'b0;
    check("res_stb dropped", 32'(res_stb), 32'd0);
    check("busy after return", 32'(busy), 32'd0);
  endtask

  task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] z);
    @(negedge clk);
    set_ops(idx, a, b, sub);
    req_stb[idx] = 1'b1;
    wait_accept(idx);
    wait_result(idx, z);
    take_result(idx);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req_ack"},     32'(req_ack),     32'd0);
    check({tag, " res_stb"},     32'(res_stb),     32'd0);
    check({tag, " res_z"},       res_z,            32'd0);
    check({tag, " adder_a"},     adder_a,          32'd0);
    check({tag, " adder_b"},     adder_b,          32'd0);
    check({tag, " adder_a_stb"}, 32'(adder_a_stb), 32'd0);
    check({tag, " adder_b_stb"}, 32'(adder_b_stb), 32'd0);
    check({tag, " adder_z_ack"}, 32'(adder_z_ack), 32'd0);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " grant"},       32'(grant),       32'd0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] z;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] rr_a [N];
  logic [31:0] rr_b [N];
  logic [31:0] rr_z [N];

  initial begin
    rr_a[0] = 32'h3F80_0000; rr_b[0] = 32'h3F80_0000; rr_z[0] = 32'h4000_0000;
    rr_a[1] = 32'h4000_0000; rr_b[1] = 32'h4000_0000; rr_z[1] = 32'h4080_0000;
    rr_a[2] = 32'h3F80_0000; rr_b[2] = 32'h4000_0000; rr_z[2] = 32'h4040_0000;
    rr_a[3] = 32'h4000_0000; rr_b[3] = 32'h4080_0000; rr_z[3] = 32'h40C0_0000;

    vecs.push_back('{2, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000});
    vecs.push_back('{0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000});
    vecs.push_back('{1, 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000});
    vecs.push_back('{3, 32'h4000_0000, 32'h4080_0000, 1'b0, 32'h40C0_0000});
    vecs.push_back('{1, 32'h4040_0000, 32'h3F80_0000, 1'b0, 32'h4080_0000});
`ifdef ADDER_ARBITER_SUB_EN
    vecs.push_back('{1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000});
    req_sub = '0;
`endif

    rst = 1'b1; req_a = '0; req_b = '0; req_stb = '0; res_ack = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].z);

    // Round robin: everyone requests continuously and always accepts results.
    pulse_reset();
    for (int i = 0; i < N; i++) set_ops(i, rr_a[i], rr_b[i], 1'b0);
    req_stb = '1;
    res_ack = '1;
    begin
      int ng = 0;
      int nr = 0;
      for (int c = 0; c < 600 && nr < 8; c++) begin
        @(negedge clk);
        if (req_ack != '0) begin
          check("rr grant", 32'(grant), 32'(ng % N));
          check("rr req_ack", 32'(req_ack), 32'(1) << (ng % N));
          ng++;
        end
        if (res_stb != '0) begin
          check("rr res_stb", 32'(res_stb), 32'(1) << (nr % N));
          check("rr res_z", res_z, rr_z[nr % N]);
          nr++;
          if (nr == 8) req_stb = '0;
        end
      end
      if (nr < 8) timeout("round robin results");
    end
    @(negedge clk);
    res_ack = '0;
    check("rr busy at end", 32'(busy), 32'd0);

    // Stalled result: owner 2 holds off res_ack while requester 0 waits.
    pulse_reset();
    set_ops(2, rr_a[2], rr_b[2], 1'b0);
    req_stb[2] = 1'b1;
    wait_accept(2);
    wait_result(2, rr_z[2]);
    set_ops(0, rr_a[0], rr_b[0], 1'b0);
    req_stb[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold res_stb", 32'(res_stb), 32'h4);
      check("hold res_z", res_z, rr_z[2]);
      check("hold req_ack", 32'(req_ack), 32'd0);
    end
    take_result(2);
    wait_accept(0);
    wait_result(0, rr_z[0]);
    take_result(0);

    // Reset while the adder result is outstanding.
    pulse_reset();
    set_ops(3, rr_a[3], rr_b[3], 1'b0);
    req_stb[3] = 1'b1;
    wait_accept(3);
    begin
      int cyc = 0;
      while (adder_z_ack == 1'b0 && cyc < 40) begin @(negedge clk); cyc++; end
      if (adder_z_ack == 1'b0) timeout("wait_z");
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midop reset");
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("no stale result", 32'(res_stb), 32'd0);
    end
    run_op(0, rr_a[0], rr_b[0], 1'b0, rr_z[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin scheduler that shares one single-precision `adder` instance between N requesters. Each requester submits an operand pair over a stb/ack handshake. The block serialises the operands into the adder's `input_a` and `input_b` ports, collects `output_z`, and returns the result to the requester that issued the operation. It sits between client datapaths and the adder, with exactly one operation in flight.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `IDX_W`, default `$clog2(N)`: width of the grant index (derived).
- `clk  in  1`: single clock.
- `rst  in  1`: synchronous, active-high reset.
- `req_a  in  32*N`: operand A; requester i occupies bits `[32i+31:32i]`.
- `req_b  in  32*N`: operand B, same packing as `req_a`.
- `req_sub  in  N`: present only with `ADDER_ARBITER_SUB_EN`; 1 means compute a−b.
- `req_stb  in  N`: request strobe, one bit per requester.
- `req_ack  out  N`: request accept, one bit per requester.
- `res_z  out  32`: result bus, shared by all requesters.
- `res_stb  out  N`: result valid; only the owning requester's bit is set.
- `res_ack  in  N`: result accept.
- `adder_a  out  32` / `adder_a_stb  out  1` / `adder_a_ack  in  1`: adder operand A handshake.
- `adder_b  out  32` / `adder_b_stb  out  1` / `adder_b_ack  in  1`: adder operand B handshake.
- `adder_z  in  32` / `adder_z_stb  in  1` / `adder_z_ack  out  1`: adder result handshake.
- `busy  out  1`: high whenever the FSM is not in IDLE.
- `grant  out  IDX_W`: index of the current owner.

## Operation
- Handshake rule on every port: a transfer occurs at a rising edge where stb && ack are both 1.
  - A source holds its data and stb until that transfer.
  - Every stb and ack driven by this block is a registered output.
- FSM states: IDLE, ACCEPT, SEND_A, SEND_B, WAIT_Z, RETURN.
- IDLE
  - If any `req_stb` bit is set: pick winner w by round-robin, starting at `last+1` mod N.
  - Register `grant<=w` and `req_ack[w]<=1`, then go to ACCEPT.
- ACCEPT
  - On `req_stb[w] && req_ack[w]`: latch a, b and sub; set `req_ack<=0`; go to SEND_A.
- SEND_A
  - Drive `adder_a=a` and `adder_a_stb<=1`.
  - On transfer: drop stb, go to SEND_B.
- SEND_B
  - Drive `adder_b=b`, or `{~b[31],b[30:0]}` when sub=1.
  - On transfer: drop stb, go to WAIT_Z.
- WAIT_Z
  - Set `adder_z_ack<=1`.
  - On transfer: latch z, drop ack, go to RETURN.
- RETURN
  - Set `res_z<=z` and `res_stb[w]<=1`.
  - On `res_stb[w] && res_ack[w]`: drop stb, set `last<=w`, go to IDLE.
- Round-robin pointer `last` resets to N−1, so requester 0 has first priority after reset.
- Arbitration occurs only in IDLE.
  - Requests arriving during an operation wait; they are not lost.
  - A requester with a pending result may raise `req_stb` again. It is considered only after its RETURN completes, and then at lowest priority.
- Simultaneous requests: exactly one winner. The other `req_ack` bits stay 0.
- Sign flip for subtraction is a bit operation only; NaN operands keep the NaN result of the adder.

## Timing
- Reset values: `req_ack=0`, `res_stb=0`, `res_z=0`, `adder_a_stb=0`, `adder_b_stb=0`, `adder_z_ack=0`, `adder_a=0`, `adder_b=0`, `busy=0`, `grant=0`, state=IDLE.
- Arbiter overhead: 1 cycle in IDLE, 1 in ACCEPT, and at least 1 each in SEND_A, SEND_B, WAIT_Z and RETURN.
- Back-to-back operations: the next IDLE arbitration happens in the cycle after the RETURN transfer.
- `busy` rises the cycle after IDLE detects a request and falls the cycle after the RETURN transfer.
- Reset mid-operation:
  - All outputs take their reset values on the next edge and state returns to IDLE.
  - The in-flight operation is discarded and no result is delivered.
  - The adder must share `rst`.
- `grant` is stable from ACCEPT through RETURN.

## Configuration
- `ADDER_ARBITER_SUB_EN` defined:
  - The `req_sub` port exists.
  - It is latched in ACCEPT.
  - When it is 1, the operand B sign bit is inverted before SEND_B.
- Not defined:
  - The `req_sub` port is absent.
  - B is always sent unmodified (add only).

## Structure
- Shared package `adder_arbiter_pkg` holds:
  - the FSM state encoding, width 3;
  - the constant `SIGN_BIT=31`.
- Sub-module `rr_pick`: purely combinational round-robin picker.
  - Inputs: request vector, `last`.
  - Outputs: winner index, `any` flag.

## Test plan
- N=4, requester 2 sends a=0x3F800000, b=0x40000000 → `res_stb[2]` with `res_z=0x40400000`; no other `res_stb` bit asserts.
- With `ADDER_ARBITER_SUB_EN`: requester 1 sends a=0x40400000, b=0x3F800000, sub=1 → `res_z=0x40000000`.
- All four `req_stb` bits asserted together after reset, each re-requesting immediately → grant order 0,1,2,3,0,1…; each result returned to its owner.
- `res_ack[w]` held low for 10 cycles in RETURN → `res_stb[w]` and `res_z` stay stable; no new `req_ack` is asserted until the transfer.
- `rst` pulsed during WAIT_Z → next cycle all outputs take reset values and `busy=0`; a fresh request then completes correctly from requester 0.
